count_seg7_display: RTL and testbench

- Downstream display stage for the 8-bit free-running event counter.
- Takes the counter's binary value, converts it to three BCD digits with a sequential shift-add-3 engine, and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Runs on the board clock, not the divided tick. Decimal range is 0..255.

---
 rtl/count_seg7_display.sv | 132 +++++++++++++
 tb/tb_count_seg7_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_seg7_display.sv
// count_seg7_display: converts an 8-bit count to BCD with a sequential
// shift-add-3 engine and time-multiplexes three digits onto a common-anode display.
module count_seg7_display #(
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       busy
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    last_q, last_d;
   logic [7:0]    bin_q, bin_d;
   logic [9:0]    bcd_q, bcd_d;
   logic [2:0]    iter_q, iter_d;
   logic          busy_q, busy_d;
   logic [9:0]    shown_q, shown_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    slot_q, slot_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic [9:0]    adj;
   logic [3:0]    digit;
   logic          blank;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return n >= 4'd5 ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Hundreds never exceeds 2 while shifting, so it needs no correction.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      shown_d = shown_q;
      adj     = {bcd_q[9:8], add3(bcd_q[7:4]), add3(bcd_q[3:0])};
      case (state_q)
         IDLE: if (value != last_q) begin
            bin_d   = value;
            last_d  = value;
            bcd_d   = '0;
            iter_d  = '0;
            busy_d  = 1'b1;
            state_d = CONV;
         end
         CONV: begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            iter_d         = iter_q + 3'd1;
            state_d        = iter_q == 3'd7 ? DONE : CONV;
         end
         DONE: begin
            shown_d = bcd_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q == TERM ? '0 : cnt_q + 1'b1;
      slot_d = cnt_q == TERM ? slot_q + 2'd1 : slot_q;
      digit  = slot_q == 2'd0 ? shown_q[3:0] :
               slot_q == 2'd1 ? shown_q[7:4] : {2'b00, shown_q[9:8]};
      blank  = slot_q == 2'd3 ||
               (BLANK_LZ && ((slot_q == 2'd2 && shown_q[9:8] == 2'd0) ||
                             (slot_q == 2'd1 && shown_q[9:4] == 6'd0)));
      an_d   = blank ? 4'b1111 : ~(4'b0001 << slot_q);
      seg_d  = blank ? 7'b1111111 : seg_code(digit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         shown_q <= '0;
         cnt_q   <= '0;
         slot_q  <= '0;
         an_q    <= 4'b1111;
         seg_q   <= 7'b1111111;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         busy_q  <= busy_d;
         shown_q <= shown_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign dp   = 1'b1;
   assign busy = busy_q;
endmodule

// File: tb/tb_count_seg7_display.sv
// tb_count_seg7_display: checks conversion latency and multiplexed display
// output of two instances (leading-zero blanking on and off) against a decimal model.
module tb_count_seg7_display;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] value = 8'd0;
   logic [3:0] an, an0;
   logic [6:0] seg, seg0;
   logic       dp, dp0, busy, busy0;
   int         checks = 0;
   int         errors = 0;
   int         cur = 0;
   logic [6:0] code [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   count_seg7_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .value(value), .an(an), .seg(seg), .dp(dp), .busy(busy));
   count_seg7_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nz (
      .clk(clk), .rst(rst), .value(value), .an(an0), .seg(seg0), .dp(dp0), .busy(busy0));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   function automatic void expect_slot(input int v, input int k, input bit lz,
                                       output logic [3:0] ea, output logic [6:0] es);
      int d;
      bit bl;
      d  = k == 0 ? v % 10 : k == 1 ? (v / 10) % 10 : v / 100;
      bl = k == 3 || (lz && k == 1 && v < 10) || (lz && k == 2 && v < 100);
      ea = bl ? 4'b1111 : ~(4'b0001 << k);
      es = bl ? 7'b1111111 : code[d];
   endfunction

   task automatic wait_conv(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) n++;
         else if (n > 0) break;
      end
   endtask

   task automatic check_frame(input int v);
      logic [3:0] prev, ea;
      logic [6:0] es;
      int n;
      prev = 4'b1110;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (an == 4'b1110 && prev != 4'b1110) break;
         prev = an;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL frame_sync v=%0d: no slot 0 start seen, an=%b", v, an);
         return;
      end
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         expect_slot(v, i / 4, 1'b1, ea, es);
         checks++;
         if ({an, seg, dp} !== {ea, es, 1'b1}) begin
            errors++;
            $display("FAIL frame_lz v=%0d cyc=%0d an/seg/dp=%b/%b/%b exp=%b/%b/1", v, i, an, seg, dp, ea, es);
         end
         expect_slot(v, i / 4, 1'b0, ea, es);
         checks++;
         if ({an0, seg0, dp0} !== {ea, es, 1'b1}) begin
            errors++;
            $display("FAIL frame_nz v=%0d cyc=%0d an/seg/dp=%b/%b/%b exp=%b/%b/1", v, i, an0, seg0, dp0, ea, es);
         end
      end
   endtask

   task automatic convert_and_check(input int v);
      int n;
      value = 8'(v);
      wait_conv(n);
      checks++;
      if (n !== 9) begin
         errors++;
         $display("FAIL busy_len v=%0d got=%0d exp=9", v, n);
      end
      cur = v;
      check_frame(v);
   endtask

   task automatic test_reset;
      int n;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({an, seg, dp, busy} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs got=%b/%b/%b/%b exp=1111/1111111/1/0", an, seg, dp, busy);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL reset_idle_busy got=%0d busy cycles exp=0", n);
      end
      check_frame(0);
   endtask

   task automatic test_directed;
      convert_and_check(255);
      convert_and_check(7);
      convert_and_check(105);
   endtask

   task automatic test_back_to_back;
      logic [3:0] ea;
      logic [6:0] es;
      int k, seen, n;
      value = 8'd200;
      repeat (3) @(negedge clk);
      value = 8'd42;
      for (n = 0; n < 20 && busy; n++) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first_done busy=%b exp=0", busy);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL b2b_restart busy=%b exp=1", busy);
            end
         end
         if (an0 != 4'b1111) begin
            k = an0 == 4'b1110 ? 0 : an0 == 4'b1101 ? 1 : 2;
            expect_slot(200, k, 1'b0, ea, es);
            seen++;
            checks++;
            if ({an0, seg0} !== {ea, es}) begin
               errors++;
               $display("FAIL b2b_show200 cyc=%0d an/seg=%b/%b exp=%b/%b", i, an0, seg0, ea, es);
            end
         end
      end
      checks++;
      if (seen == 0) begin
         errors++;
         $display("FAIL b2b_show200_seen got=0 digit samples exp>0");
      end
      for (n = 0; n < 20 && busy; n++) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_done busy=%b exp=0", busy);
      end
      cur = 42;
      check_frame(42);
   endtask

   task automatic test_async_reset;
      value = 8'd99;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({an, seg, busy, an0, seg0, busy0} !== {4'b1111, 7'b1111111, 1'b0, 4'b1111, 7'b1111111, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got=%b/%b/%b %b/%b/%b exp=1111/1111111/0", an, seg, busy, an0, seg0, busy0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      convert_and_check(99);
   endtask

   task automatic test_random;
      int v, n;
      repeat (8) begin
         v = $urandom_range(0, 255);
         if (v == cur) begin
            value = 8'(v);
            n = 0;
            repeat (12) begin
               @(negedge clk);
               if (busy) n++;
            end
            checks++;
            if (n != 0) begin
               errors++;
               $display("FAIL same_value_busy v=%0d got=%0d exp=0", v, n);
            end
         end else begin
            convert_and_check(v);
         end
      end
      value = 8'(cur);
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL unchanged_busy v=%0d got=%0d exp=0", cur, n);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
